serial_tx_sched: RTL and testbench
==================================

// Module: serial_tx_sched
// PURPOSE
//   Round-robin scheduler that shares one 6-bit parallel-to-serial shifter among NREQ requesters.
//   - Accepts one word from the winning requester.
//   - Pulses ser_load with that word into the shifter.
//   - Counts the W serial bits and qualifies them onto the framed line output (first/last strobes).
//   - Returns to arbitration when the frame ends.
//   Sits between the request sources and the shifter; the shifter is clocked and reset alongside this block.
// PARAMETERS
//   NREQ  4  number of requesters (>=2)
//   W     6  data word width = serial bits per frame
//   IDW   $clog2(NREQ)  grant id width (localparam, not overridable)
// PORTS
//   clk         in   1         clock, all state on posedge
//   rst         in   1         asynchronous, active-high reset
//   req_valid   in   NREQ      per-requester word available
//   req_data    in   NREQ*W    packed words; requester i at [i*W +: W]
//   req_ready   out  NREQ      one-hot accept pulse; word consumed when valid&ready
//   ser_num     out  W         word to shifter, meaningful while ser_load=1
//   ser_load    out  1         shifter load strobe
//   ser_in      in   1         shifter serial output; MSB is valid the cycle after ser_load, then 1 bit/cycle
//   line_out    out  1         framed serial bit
//   line_valid  out  1         line_out qualifier
//   line_first  out  1         first bit of frame
//   line_last   out  1         last bit of frame
//   grant_id    out  IDW       owner of current frame
//   busy        out  1         frame in progress
// BEHAVIOUR
//   Reset: all outputs 0; state=IDLE; rr pointer=NREQ-1, so requester 0 has first priority; bit count=0.
//   Reset mid-frame aborts the frame; no partial-frame recovery.
//   States: IDLE, SHIFT, PARITY (PARITY exists only with SER_PARITY_EN).
//   IDLE:
//     - No req_valid: stay; ser_load=0, busy=0.
//     - Otherwise pick the first valid index searching from ptr+1 upward, wrapping modulo NREQ.
//     - Same cycle: req_ready[win]=1, ser_load=1, ser_num=req_data[win].
//     - Registered: grant_id<=win, ptr<=win, cnt<=0, state<=SHIFT.
//   SHIFT:
//     - Outputs: line_valid=1, line_out=ser_in (combinational); busy=1.
//     - line_first=(cnt==0); line_last=(cnt==W-1) when parity is compiled out.
//     - cnt increments each cycle.
//     - At cnt==W-1: go to PARITY if enabled, else IDLE.
//   Frame timing:
//     - Accept at cycle t; bits at t+1..t+W; IDLE (gap, line_valid=0) at t+W+1.
//     - Earliest next accept is t+W+1 (the gap cycle itself). Period is W+1 cycles, W+2 with parity.
//   Arbitration rules:
//     - req_valid deasserting while waiting in IDLE is legal; no accept is issued.
//     - req_valid/req_data are ignored outside IDLE; exactly one req_ready pulse per frame.
//     - A requester holding valid continuously cannot win twice in a row if another requester is valid.
//   Wrap-around: the search index wraps NREQ-1 -> 0; the bit counter is exactly clog2(W) bits, with no overflow past W-1.
// CONFIGURATION
//   SER_PARITY_EN defined:
//     - Even parity = ^word, computed on the accepted word and held in a register.
//     - PARITY state: line_out=parity, line_valid=1, line_last=1; next state IDLE.
//     - line_last is not asserted in SHIFT.
//   SER_PARITY_EN undefined: the PARITY state, parity register and logic are absent; frame is W bits.
// STRUCTURE
//   Shared package ser_pkg: state encoding (ST_IDLE/ST_SHIFT/ST_PARITY), default W=6, NREQ=4.
//   One sub-module: rr_arbiter (NREQ) - inputs req_valid and ptr; outputs one-hot grant plus encoded index; purely combinational.
//   Top holds the FSM, counter, ptr, grant_id and parity register.
// TESTING (bench: NREQ=4, W=6, behavioural shifter model on ser_load/ser_in)
//   - Reset, req_valid=0001, data0=6'b101100:
//     - ready[0]=1 and ser_load=1 in cycle 0.
//     - line_out=1,0,1,1,0,0 in cycles 1-6; first@1, last@6; valid=0 in cycle 7.
//   - req_valid=1111 held, distinct data:
//     - Grant order 0,1,2,3,0.
//     - Accepts exactly 7 cycles apart (8 with SER_PARITY_EN).
//   - ptr=2, req_valid=0011 -> grant 0, then 1 (wrap-around).
//   - rst asserted on cycle 3 of a frame:
//     - All outputs 0 immediately.
//     - Next frame grants requester 0.
//   - SER_PARITY_EN, data=6'b111000 -> parity bit=1 at cycle 7 with line_last; data=6'b110000 -> 0.
//   - req_valid pulses 1 cycle while busy -> no ready issued; counter and grant_id unchanged.

Source files
------------

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encoding and default sizes for the serial tx scheduler
package ser_pkg;

    localparam int W_DEF    = 6;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic found;
    int   c;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        // Walk ptr+1 .. ptr+NREQ so the last winner is tried last.
        for (int k = 1; k <= NREQ; k++) begin
            c = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/serial_tx_sched.sv
// rtl/serial_tx_sched.sv - round-robin scheduler framing one shared shifter's output
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module serial_tx_sched
    import ser_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      ser_num,
    output logic              ser_load,
    input  logic              ser_in,
    output logic              line_out,
    output logic              line_valid,
    output logic              line_first,
    output logic              line_last,
    output logic [IDW-1:0]    grant_id,
    output logic              busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win;
    logic [W-1:0]    win_word;
    logic            accept;
    logic            cnt_end;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_valid(req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .idx      (win)
    );

    assign win_word = req_data[int'(win)*W +: W];
    // Gated by rst so nothing leaks out while reset is held.
    assign accept   = (state == ST_IDLE) && (|req_valid) && !rst;
    assign cnt_end  = (cnt == CW'(W-1));

`ifdef SER_PARITY_EN
    logic parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity <= 1'b0;
        else if (accept)
            parity <= ^win_word;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ptr      <= IDW'(NREQ-1);
            grant_id <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        grant_id <= win;
                        ptr      <= win;
                        cnt      <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_end) begin
                        cnt <= '0;
`ifdef SER_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_IDLE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SER_PARITY_EN
                ST_PARITY: state <= ST_IDLE;
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = accept ? grant : '0;
    assign ser_load   = accept;
    assign ser_num    = accept ? win_word : '0;
    assign busy       = (state != ST_IDLE);
    assign line_first = (state == ST_SHIFT) && (cnt == '0);

`ifdef SER_PARITY_EN
    assign line_valid = (state == ST_SHIFT) || (state == ST_PARITY);
    assign line_out   = (state == ST_SHIFT) ? ser_in : ((state == ST_PARITY) && parity);
    assign line_last  = (state == ST_PARITY);
`else
    assign line_valid = (state == ST_SHIFT);
    assign line_out   = (state == ST_SHIFT) && ser_in;
    assign line_last  = (state == ST_SHIFT) && cnt_end;
`endif

endmodule

// File: tb/tb_serial_tx_sched.sv
// tb/tb_serial_tx_sched.sv - directed self-checking bench for serial_tx_sched
module tb_serial_tx_sched;

    localparam int NREQ = 4;
    localparam int W    = 6;
    localparam int IDW  = 2;
`ifdef SER_PARITY_EN
    localparam int PERIOD = W + 2;
`else
    localparam int PERIOD = W + 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      ser_num;
    logic              ser_load;
    logic              ser_in;
    logic              line_out;
    logic              line_valid;
    logic              line_first;
    logic              line_last;
    logic [IDW-1:0]    grant_id;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] dat [NREQ];
    logic [W-1:0] sh;

    serial_tx_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .ser_num(ser_num), .ser_load(ser_load), .ser_in(ser_in),
        .line_out(line_out), .line_valid(line_valid), .line_first(line_first),
        .line_last(line_last), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural shifter: loads on ser_load, presents MSB next cycle.
    always @(posedge clk or posedge rst) begin
        if (rst)
            sh <= '0;
        else if (ser_load)
            sh <= ser_num;
        else
            sh <= {sh[W-2:0], 1'b0};
    end
    assign ser_in = sh[W-1];

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (got timeout, required completion)");
        $fatal(1);
    end

    task step();
        @(posedge clk);
        #1;
    endtask

    task load_data();
        for (int j = 0; j < NREQ; j++)
            req_data[j*W +: W] = dat[j];
    endtask

    task apply_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        dat = '{6'h0B, 6'h16, 6'h2D, 6'h33};
        load_data();
        step();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", req_ready); else n_pass++;
        n_checks++;
        if (ser_load !== 1'b0) $display("FAIL reset_load got %b want 0", ser_load); else n_pass++;
        n_checks++;
        if ({line_out, line_valid, line_first, line_last, busy} !== 5'b0)
            $display("FAIL reset_line got %b want 00000", {line_out, line_valid, line_first, line_last, busy});
        else n_pass++;
        n_checks++;
        if (grant_id !== 2'd0) $display("FAIL reset_grant got %0d want 0", grant_id); else n_pass++;
        n_checks++;
        if (ser_num !== 6'd0) $display("FAIL reset_num got %h want 0", ser_num); else n_pass++;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task test_single();
        logic [W-1:0] w;
        w = 6'b101100;
        apply_reset();
        dat = '{w, 6'h00, 6'h00, 6'h00};
        load_data();
        req_valid = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001 || ser_load !== 1'b1)
            $display("FAIL single_accept got ready=%b load=%b want 0001/1", req_ready, ser_load);
        else n_pass++;
        n_checks++;
        if (ser_num !== w) $display("FAIL single_num got %b want %b", ser_num, w); else n_pass++;
        step();
        req_valid = '0;
        for (int i = 1; i <= W; i++) begin
            logic exp_last;
`ifdef SER_PARITY_EN
            exp_last = 1'b0;
`else
            exp_last = (i == W);
`endif
            @(negedge clk);
            n_checks++;
            if (line_valid !== 1'b1 || line_out !== w[W-i] || busy !== 1'b1)
                $display("FAIL single_bit%0d got v=%b d=%b busy=%b want 1/%b/1", i, line_valid, line_out, busy, w[W-i]);
            else n_pass++;
            n_checks++;
            if (line_first !== (i == 1) || line_last !== exp_last)
                $display("FAIL single_strobe%0d got first=%b last=%b want %b/%b", i, line_first, line_last, (i == 1), exp_last);
            else n_pass++;
            step();
        end
`ifdef SER_PARITY_EN
        step();
`endif
        @(negedge clk);
        n_checks++;
        if (line_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_gap got v=%b busy=%b want 0/0", line_valid, busy);
        else n_pass++;
    endtask

    task test_round_robin();
        int order [5];
        int n, last_t, idx;
        order = '{0, 1, 2, 3, 0};
        apply_reset();
        dat = '{6'h0B, 6'h16, 6'h2D, 6'h33};
        load_data();
        req_valid = 4'b1111;
        n = 0;
        last_t = -1;
        for (int t = 0; t < 60 && n < 5; t++) begin
            @(negedge clk);
            if (ser_load === 1'b1) begin
                idx = -1;
                for (int j = 0; j < NREQ; j++)
                    if (req_ready[j]) idx = j;
                n_checks++;
                if (!$onehot(req_ready) || idx != order[n])
                    $display("FAIL rr_grant%0d got ready=%b want index %0d", n, req_ready, order[n]);
                else n_pass++;
                n_checks++;
                if (ser_num !== dat[order[n]])
                    $display("FAIL rr_data%0d got %h want %h", n, ser_num, dat[order[n]]);
                else n_pass++;
                if (n > 0) begin
                    n_checks++;
                    if (t - last_t != PERIOD)
                        $display("FAIL rr_period%0d got %0d want %0d", n, t - last_t, PERIOD);
                    else n_pass++;
                end
                last_t = t;
                n++;
            end
            step();
        end
        n_checks++;
        if (n != 5) $display("FAIL rr_count got %0d want 5", n); else n_pass++;
        req_valid = '0;
    endtask

    task test_wrap();
        int order [3];
        int n, idx;
        order = '{2, 0, 1};
        apply_reset();
        dat = '{6'h0B, 6'h16, 6'h2D, 6'h33};
        load_data();
        req_valid = 4'b0100;
        n = 0;
        for (int t = 0; t < 60 && n < 3; t++) begin
            @(negedge clk);
            if (ser_load === 1'b1) begin
                idx = -1;
                for (int j = 0; j < NREQ; j++)
                    if (req_ready[j]) idx = j;
                n_checks++;
                if (idx != order[n])
                    $display("FAIL wrap_grant%0d got %0d want %0d", n, idx, order[n]);
                else n_pass++;
                n++;
            end
            step();
            if (n == 1) req_valid = 4'b0011;
        end
        n_checks++;
        if (n != 3) $display("FAIL wrap_count got %0d want 3", n); else n_pass++;
        req_valid = '0;
    endtask

    task test_reset_mid();
        apply_reset();
        dat = '{6'h0B, 6'h16, 6'h3F, 6'h33};
        load_data();
        req_valid = 4'b0100;
        step();
        req_valid = 4'b1111;
        step();
        @(negedge clk);
        n_checks++;
        if (grant_id !== 2'd2 || busy !== 1'b1)
            $display("FAIL rstmid_pre got grant=%0d busy=%b want 2/1", grant_id, busy);
        else n_pass++;
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({line_out, line_valid, line_first, line_last, busy, ser_load} !== 6'b0 || req_ready !== 4'b0 || grant_id !== 2'd0)
            $display("FAIL rstmid_outputs got line=%b ready=%b grant=%0d want all zero",
                     {line_out, line_valid, line_first, line_last, busy, ser_load}, req_ready, grant_id);
        else n_pass++;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ser_load !== 1'b1 || req_ready !== 4'b0001)
            $display("FAIL rstmid_next got load=%b ready=%b want 1/0001", ser_load, req_ready);
        else n_pass++;
        step();
        req_valid = '0;
    endtask

    task test_busy_pulse();
        logic exp_last6;
`ifdef SER_PARITY_EN
        exp_last6 = 1'b0;
`else
        exp_last6 = 1'b1;
`endif
        apply_reset();
        dat = '{6'b101100, 6'h16, 6'h2D, 6'h33};
        load_data();
        req_valid = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL pulse_accept got %b want 0001", req_ready); else n_pass++;
        step();
        req_valid = '0;
        step();
        step();
        req_valid = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0 || ser_load !== 1'b0 || line_first !== 1'b0)
            $display("FAIL pulse_ignored got ready=%b load=%b first=%b want 0000/0/0", req_ready, ser_load, line_first);
        else n_pass++;
        step();
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (grant_id !== 2'd0) $display("FAIL pulse_grant got %0d want 0", grant_id); else n_pass++;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if (line_last !== exp_last6 || line_valid !== 1'b1)
            $display("FAIL pulse_count got last=%b v=%b want %b/1", line_last, line_valid, exp_last6);
        else n_pass++;
        step();
`ifdef SER_PARITY_EN
        step();
`endif
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 4'b0)
            $display("FAIL pulse_gap got busy=%b ready=%b want 0/0000", busy, req_ready);
        else n_pass++;
    endtask

`ifdef SER_PARITY_EN
    task test_parity();
        logic [W-1:0] words [2];
        logic         pbit  [2];
        words = '{6'b111000, 6'b110000};
        pbit  = '{1'b1, 1'b0};
        apply_reset();
        for (int f = 0; f < 2; f++) begin
            dat = '{words[f], 6'h00, 6'h00, 6'h00};
            load_data();
            req_valid = 4'b0001;
            @(negedge clk);
            n_checks++;
            if (ser_load !== 1'b1) $display("FAIL par_accept%0d got %b want 1", f, ser_load); else n_pass++;
            step();
            req_valid = '0;
            for (int i = 1; i < W; i++) step();
            @(negedge clk);
            n_checks++;
            if (line_last !== 1'b0) $display("FAIL par_nolast%0d got %b want 0", f, line_last); else n_pass++;
            step();
            @(negedge clk);
            n_checks++;
            if (line_valid !== 1'b1 || line_last !== 1'b1 || line_out !== pbit[f])
                $display("FAIL par_bit%0d got v=%b last=%b d=%b want 1/1/%b", f, line_valid, line_last, line_out, pbit[f]);
            else n_pass++;
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_busy_pulse();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
